// File: rtl/vec_check_if.sv
// Bundle between vec_check, its host (vector load/start/status) and the datapath under test.
// Optional first-fail capture ports exist only when VEC_CHECK_FIRST_FAIL_EN is defined.
interface vec_check_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 3
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [WIDTH-1:0]  load_stim;
  logic [WIDTH-1:0]  load_exp;
  logic              start;
  logic [WIDTH-1:0]  x_out;
  logic [WIDTH-1:0]  y_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_count;
`ifdef VEC_CHECK_FIRST_FAIL_EN
  logic              fail_valid;
  logic [ADDR_W-1:0] fail_idx;
  logic [WIDTH-1:0]  fail_act;
`endif

  // master: the checker itself; slave: host plus datapath side
  modport master (
`ifdef VEC_CHECK_FIRST_FAIL_EN
    output fail_valid, fail_idx, fail_act,
`endif
    input  load_en, load_addr, load_stim, load_exp, start, y_in,
    output x_out, busy, done, pass, err_count
  );

  modport slave (
`ifdef VEC_CHECK_FIRST_FAIL_EN
    input  fail_valid, fail_idx, fail_act,
`endif
    output load_en, load_addr, load_stim, load_exp, start, y_in,
    input  x_out, busy, done, pass, err_count
  );
endinterface

// File: rtl/vec_check.sv
// Hardware vector checker: drives stored stimulus into a pipelined datapath and counts mismatches.
// Optional first-fail capture (index + actual value) enabled by VEC_CHECK_FIRST_FAIL_EN.
module vec_check #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 6,
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic rst_n,
  vec_check_if.master bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [LATENCY:0]  dl_vld_q, dl_vld_d;
  logic [WIDTH-1:0]  dl_exp_q [LATENCY+1];
  logic [WIDTH-1:0]  dl_exp_d [LATENCY+1];
`ifdef VEC_CHECK_FIRST_FAIL_EN
  logic [ADDR_W-1:0] dl_idx_q [LATENCY+1];
  logic [ADDR_W-1:0] dl_idx_d [LATENCY+1];
  logic              fail_vld_q, fail_vld_d;
  logic [ADDR_W-1:0] fail_idx_q, fail_idx_d;
  logic [WIDTH-1:0]  fail_act_q, fail_act_d;
`endif

  logic [WIDTH-1:0]  stim_mem [DEPTH];
  logic [WIDTH-1:0]  exp_mem  [DEPTH];

  logic              idle_like, load_ok, fwd, mismatch;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  stim_rd, exp_rd;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign load_ok   = bus.load_en && idle_like &&
                     ({1'b0, bus.load_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_addr   = (state_q == DRIVE) ? idx_q : '0;
  // A write in the start cycle must be seen by vector 0, so bypass the RAM.
  assign fwd       = load_ok && (bus.load_addr == rd_addr);
  assign stim_rd   = fwd ? bus.load_stim : stim_mem[rd_addr];
  assign exp_rd    = fwd ? bus.load_exp  : exp_mem[rd_addr];
  assign mismatch  = dl_vld_q[LATENCY] && (bus.y_in != dl_exp_q[LATENCY]);

  always_ff @(posedge clk) begin
    if (load_ok) begin
      stim_mem[bus.load_addr] <= bus.load_stim;
      exp_mem[bus.load_addr]  <= bus.load_exp;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = '0;
    err_d       = err_q;
    dl_vld_d    = {dl_vld_q[LATENCY-1:0], 1'b0};
    dl_exp_d[0] = '0;
    for (int i = 1; i <= LATENCY; i++) dl_exp_d[i] = dl_exp_q[i-1];
`ifdef VEC_CHECK_FIRST_FAIL_EN
    dl_idx_d[0] = '0;
    for (int i = 1; i <= LATENCY; i++) dl_idx_d[i] = dl_idx_q[i-1];
    fail_vld_d = fail_vld_q;
    fail_idx_d = fail_idx_q;
    fail_act_d = fail_act_q;
    if (mismatch && !fail_vld_q) begin
      fail_vld_d = 1'b1;
      fail_idx_d = dl_idx_q[LATENCY];
      fail_act_d = bus.y_in;
    end
`endif
    if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = DRIVE;
          idx_d       = ADDR_W'(1);
          x_d         = stim_rd;
          err_d       = '0;
          dl_vld_d[0] = 1'b1;
          dl_exp_d[0] = exp_rd;
`ifdef VEC_CHECK_FIRST_FAIL_EN
          dl_idx_d[0] = '0;
          fail_vld_d  = 1'b0;
          fail_idx_d  = '0;
          fail_act_d  = '0;
`endif
        end
      end
      DRIVE: begin
        x_d         = stim_rd;
        dl_vld_d[0] = 1'b1;
        dl_exp_d[0] = exp_rd;
`ifdef VEC_CHECK_FIRST_FAIL_EN
        dl_idx_d[0] = idx_q;
`endif
        if (idx_q == ADDR_W'(DEPTH-1)) state_d = DRAIN;
        else                           idx_d   = idx_q + 1'b1;
      end
      DRAIN: begin
        if (dl_vld_q == '0) state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      err_q    <= '0;
      dl_vld_q <= '0;
      for (int i = 0; i <= LATENCY; i++) dl_exp_q[i] <= '0;
`ifdef VEC_CHECK_FIRST_FAIL_EN
      for (int i = 0; i <= LATENCY; i++) dl_idx_q[i] <= '0;
      fail_vld_q <= 1'b0;
      fail_idx_q <= '0;
      fail_act_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      err_q    <= err_d;
      dl_vld_q <= dl_vld_d;
      for (int i = 0; i <= LATENCY; i++) dl_exp_q[i] <= dl_exp_d[i];
`ifdef VEC_CHECK_FIRST_FAIL_EN
      for (int i = 0; i <= LATENCY; i++) dl_idx_q[i] <= dl_idx_d[i];
      fail_vld_q <= fail_vld_d;
      fail_idx_q <= fail_idx_d;
      fail_act_q <= fail_act_d;
`endif
    end
  end

  assign bus.x_out     = x_q;
  assign bus.busy      = (state_q == DRIVE) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = (state_q == DONE) && (err_q == '0);
  assign bus.err_count = err_q;
`ifdef VEC_CHECK_FIRST_FAIL_EN
  assign bus.fail_valid = fail_vld_q;
  assign bus.fail_idx   = fail_idx_q;
  assign bus.fail_act   = fail_act_q;
`endif
endmodule

// File: tb/tb_vec_check.sv
// Bench for vec_check: vector table, hand-written corner sequences and randomized runs
// against a 3-stage register pipe standing in for the datapath.
module tb_vec_check;
  localparam int WIDTH = 4, DEPTH = 6, LATENCY = 3, ADDR_W = 3, CNT_W = 3;

  typedef logic [DEPTH-1:0][WIDTH-1:0] vecs_t;
  typedef struct {
    vecs_t stim;
    vecs_t expv;
    int    exp_err;
    bit    exp_pass;
  } tvec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  vec_check_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  vec_check #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY),
              .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: y_in is x_out delayed by three clocks.
  logic [WIDTH-1:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= bus.x_out;
    p2 <= p1;
    p3 <= p2;
  end
  assign bus.y_in = p3;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_err(input vecs_t s, input vecs_t e);
    int n = 0;
    for (int k = 0; k < DEPTH; k++) if (s[k] != e[k]) n++;
    return (n > (2**CNT_W - 1)) ? (2**CNT_W - 1) : n;
  endfunction

  task automatic load_all(input vecs_t s, input vecs_t e);
    for (int k = 0; k < DEPTH; k++) begin
      bus.load_en = 1'b1;
      bus.load_addr = ADDR_W'(k);
      bus.load_stim = s[k];
      bus.load_exp = e[k];
      tick();
    end
    bus.load_en = 1'b0;
  endtask

  // poke_kind 1: extra start pulse; 2: load addr0 stim=9 while busy.
  task automatic run_vec(input vecs_t s, input vecs_t e, input int exp_err,
                         input int poke_cyc, input int poke_kind,
                         input bit ld0, input logic [WIDTH-1:0] ld0_val);
    bus.start = 1'b1;
    if (ld0) begin
      bus.load_en = 1'b1;
      bus.load_addr = '0;
      bus.load_stim = ld0_val;
      bus.load_exp = ld0_val;
    end
    tick();
    bus.start = 1'b0;
    bus.load_en = 1'b0;
    chk("e0_busy", int'(bus.busy), 1);
    chk("e0_err_clear", int'(bus.err_count), 0);
    chk("e0_done_clear", int'(bus.done), 0);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("x_out_k%0d", k), int'(bus.x_out), int'(s[k]));
      if (k + 1 == poke_cyc) begin
        if (poke_kind == 1) bus.start = 1'b1;
        if (poke_kind == 2) begin
          bus.load_en = 1'b1;
          bus.load_addr = '0;
          bus.load_stim = 4'd9;
          bus.load_exp = 4'd9;
        end
      end
      tick();
      bus.start = 1'b0;
      bus.load_en = 1'b0;
    end
    chk("drain_x_zero", int'(bus.x_out), 0);
    tick(); tick(); tick();
    chk("e9_not_done", int'(bus.done), 0);
    chk("e9_busy", int'(bus.busy), 1);
    tick();
    chk("e10_done", int'(bus.done), 1);
    chk("e10_busy", int'(bus.busy), 0);
    chk("e10_err_count", int'(bus.err_count), exp_err);
    chk("e10_pass", int'(bus.pass), (exp_err == 0) ? 1 : 0);
`ifdef VEC_CHECK_FIRST_FAIL_EN
    begin
      int first = -1;
      for (int k = DEPTH - 1; k >= 0; k--) if (s[k] != e[k]) first = k;
      chk("fail_valid", int'(bus.fail_valid), (first >= 0) ? 1 : 0);
      if (first >= 0) begin
        chk("fail_idx", int'(bus.fail_idx), first);
        chk("fail_act", int'(bus.fail_act), int'(s[first]));
      end
    end
`endif
    tick();
    chk("done_hold", int'(bus.done), 1);
  endtask

  tvec_t tbl[4];
  vecs_t one_six, all15, rs, re, tmp;

  initial begin
    bus.load_en = 1'b0;
    bus.load_addr = '0;
    bus.load_stim = '0;
    bus.load_exp = '0;
    bus.start = 1'b0;

    one_six = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    all15   = {4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    tbl[0] = '{one_six, one_six, 0, 1'b1};
    tbl[1] = '{one_six, {4'd6, 4'd5, 4'd4, 4'd9, 4'd2, 4'd1}, 1, 1'b0};
    tbl[2] = '{one_six, all15, 6, 1'b0};
    tbl[3] = '{{4'd0, 4'd15, 4'd7, 4'd8, 4'd3, 4'd12},
               {4'd0, 4'd14, 4'd7, 4'd8, 4'd3, 4'd13}, 2, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_x_out", int'(bus.x_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pass", int'(bus.pass), 0);
    chk("rst_err", int'(bus.err_count), 0);
    rst_n = 1'b1;
    tick();

    // Table: each run also checks that a start from DONE clears the previous result.
    for (int t = 0; t < 4; t++) begin
      load_all(tbl[t].stim, tbl[t].expv);
      run_vec(tbl[t].stim, tbl[t].expv, tbl[t].exp_err, 0, 0, 1'b0, '0);
      chk("tbl_pass", int'(bus.pass), int'(tbl[t].exp_pass));
    end

    // Start pulsed mid-run is ignored.
    load_all(one_six, one_six);
    run_vec(one_six, one_six, 0, 3, 1, 1'b0, '0);

    // Load while busy is ignored; the next run still drives 1 first.
    run_vec(one_six, one_six, 0, 2, 2, 1'b0, '0);
    run_vec(one_six, one_six, 0, 0, 0, 1'b0, '0);

    // Out-of-range load address leaves the RAM alone.
    bus.load_en = 1'b1;
    bus.load_addr = 3'd6;
    bus.load_stim = 4'd9;
    bus.load_exp = 4'd9;
    tick();
    bus.load_addr = 3'd7;
    tick();
    bus.load_en = 1'b0;
    run_vec(one_six, one_six, 0, 0, 0, 1'b0, '0);

    // Load and start together: vector 0 uses the new contents.
    tmp = one_six;
    tmp[0] = 4'd7;
    run_vec(tmp, tmp, 0, 0, 0, 1'b1, 4'd7);

    // Reset mid-run aborts immediately; RAM survives.
    load_all(one_six, all15);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("pre_rst_err", int'(bus.err_count), 1);
    chk("pre_rst_x", int'(bus.x_out), 5);
    rst_n = 1'b0;
    #1;
    chk("abort_x_out", int'(bus.x_out), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_err", int'(bus.err_count), 0);
    chk("abort_done", int'(bus.done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", int'(bus.done), 0);
    run_vec(one_six, all15, model_err(one_six, all15), 0, 0, 1'b0, '0);

    // Randomized runs against the counting model.
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        rs[k] = WIDTH'($urandom_range(0, 15));
        re[k] = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom_range(0, 15)) : rs[k];
      end
      load_all(rs, re);
      run_vec(rs, re, model_err(rs, re), 0, 0, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
